// File: rtl/ram_loader.sv
// ram_loader: bus-master that streams program bytes into the machine RAM.
// For every byte it drives the address onto the shared bus with the
// memory-address-register strobe, then the byte itself with the memory write
// strobe. While loading, the CPU is held in reset. An optional readback pass
// re-reads every RAM word and compares an additive checksum against the sum
// of the bytes that were sent.
//
// Handshake: a byte moves from the source when in_valid and in_ready are both
// high on a rising clock edge; in_ready is registered and only high in WAIT,
// so there is never a combinational path from in_valid to any output.
//
// All outputs are registers loaded from the next-state decode, so every
// output reflects the state the FSM is currently in.
module ram_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int VERIFY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic              wr_mem_adr,
  output logic              wr_mem,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] load_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SET_ADR,
    S_WRITE,
    S_V_ADR,
    S_V_RD,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_n;
  logic [DATA_W-1:0] tx_sum;
  logic [DATA_W-1:0] tx_n;
  logic [DATA_W-1:0] rx_sum;
  logic [DATA_W-1:0] rx_n;
  logic              err_n;
  logic [DATA_W-1:0] bus_n;
  logic              last;

  // last RAM address reached: ends the load pass and the readback pass
  assign last = (load_addr == ADDR_LAST);

  // next-state, datapath updates and the bus value for the next state
  always_comb begin
    state_n = state;
    addr_n  = load_addr;
    data_n  = data_q;
    tx_n    = tx_sum;
    rx_n    = rx_sum;
    err_n   = error;
    bus_n   = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_WAIT;
          addr_n  = '0;
          tx_n    = '0;
          rx_n    = '0;
          err_n   = 1'b0;
        end
      end
      S_WAIT: begin
        // in_ready is high for the whole of WAIT, so in_valid alone accepts
        if (in_valid) begin
          data_n  = in_data;
          tx_n    = tx_sum + in_data;
          state_n = S_SET_ADR;
        end
      end
      S_SET_ADR: begin
        state_n = S_WRITE;
      end
      S_WRITE: begin
        if (last) begin
          if (VERIFY != 0) begin
            addr_n  = '0;
            state_n = S_V_ADR;
          end else begin
            state_n = S_DONE;
          end
        end else begin
          addr_n  = load_addr + 1'b1;
          state_n = S_WAIT;
        end
      end
      S_V_ADR: begin
        state_n = S_V_RD;
      end
      S_V_RD: begin
        // the address register was loaded on the way in, so mem_rdata is valid
        rx_n = rx_sum + mem_rdata;
        if (last) begin
          state_n = S_CHECK;
        end else begin
          addr_n  = load_addr + 1'b1;
          state_n = S_V_ADR;
        end
      end
      S_CHECK: begin
        err_n   = (rx_sum != tx_sum);
        state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // the address phases put the zero-extended index on the bus, the write
    // phase puts the latched byte; everything else leaves the bus at zero
    if (state_n == S_SET_ADR || state_n == S_V_ADR) begin
      bus_n = DATA_W'(addr_n);
    end else if (state_n == S_WRITE) begin
      bus_n = data_n;
    end
  end

  // state, datapath and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      load_addr  <= '0;
      data_q     <= '0;
      tx_sum     <= '0;
      rx_sum     <= '0;
      error      <= 1'b0;
      in_ready   <= 1'b0;
      bus_out    <= '0;
      bus_drive  <= 1'b0;
      wr_mem_adr <= 1'b0;
      wr_mem     <= 1'b0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      load_addr  <= addr_n;
      data_q     <= data_n;
      tx_sum     <= tx_n;
      rx_sum     <= rx_n;
      error      <= err_n;
      in_ready   <= (state_n == S_WAIT);
      bus_out    <= bus_n;
      bus_drive  <= (state_n == S_SET_ADR) || (state_n == S_V_ADR) ||
                    (state_n == S_WRITE);
      wr_mem_adr <= (state_n == S_SET_ADR) || (state_n == S_V_ADR);
      wr_mem     <= (state_n == S_WRITE);
      cpu_hold   <= (state_n != S_IDLE) && (state_n != S_DONE);
      busy       <= (state_n != S_IDLE);
      done       <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: one instance without readback (dut0) and one with
// readback (dut1) share clock, reset, start and the byte source, each with its
// own RAM model attached to its bus strobes.
module tb_ram_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       corrupt;

  logic       in_ready0, bus_drive0, wr_mem_adr0, wr_mem0, cpu_hold0, busy0, done0, error0;
  logic [7:0] bus_out0, mem_rdata0;
  logic [3:0] load_addr0;
  logic       in_ready1, bus_drive1, wr_mem_adr1, wr_mem1, cpu_hold1, busy1, done1, error1;
  logic [7:0] bus_out1, mem_rdata1;
  logic [3:0] load_addr1;

  // RAM models
  logic [7:0] ram0 [16];
  logic [7:0] ram1 [16];
  logic [3:0] mar0, mar1;
  logic [7:0] bus_v0, bus_v1;

  // scoreboard and run bookkeeping
  logic [11:0] exp_q0 [$];
  logic [11:0] exp_q1 [$];
  int          n_checks;
  int          n_errors;
  int          cyc;
  int          s_cyc;
  int          b_idx;
  logic [7:0]  sent [16];
  bit          done_seen [2];
  int          done_cyc [2];
  logic        done_err [2];
  logic [3:0]  done_addr [2];
  int          hold_cnt [2];
  int          wr_cnt [2];
  bit          vph;
  int          v_idx;

  wire [19:0] outs0 = {in_ready0, bus_out0, bus_drive0, wr_mem_adr0, wr_mem0,
                       cpu_hold0, busy0, done0, error0, load_addr0};
  wire [19:0] outs1 = {in_ready1, bus_out1, bus_drive1, wr_mem_adr1, wr_mem1,
                       cpu_hold1, busy1, done1, error1, load_addr1};

  ram_loader #(.ADDR_W(4), .DATA_W(8), .VERIFY(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready0), .mem_rdata(mem_rdata0),
    .bus_out(bus_out0), .bus_drive(bus_drive0), .wr_mem_adr(wr_mem_adr0),
    .wr_mem(wr_mem0), .cpu_hold(cpu_hold0), .busy(busy0), .done(done0),
    .error(error0), .load_addr(load_addr0)
  );

  ram_loader #(.ADDR_W(4), .DATA_W(8), .VERIFY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready1), .mem_rdata(mem_rdata1),
    .bus_out(bus_out1), .bus_drive(bus_drive1), .wr_mem_adr(wr_mem_adr1),
    .wr_mem(wr_mem1), .cpu_hold(cpu_hold1), .busy(busy1), .done(done1),
    .error(error1), .load_addr(load_addr1)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // bus and RAM models: address register and array written by the strobes
  assign bus_v0 = bus_drive0 ? bus_out0 : 8'h00;
  assign bus_v1 = bus_drive1 ? bus_out1 : 8'h00;
  assign mem_rdata0 = ram0[mar0];
  assign mem_rdata1 = (corrupt && mar1 == 4'd5) ? 8'hFF : ram1[mar1];

  always @(posedge clk) begin
    if (wr_mem_adr0) mar0 <= bus_v0[3:0];
    if (wr_mem0) ram0[mar0] <= bus_v0;
  end

  always @(posedge clk) begin
    if (wr_mem_adr1) mar1 <= bus_v1[3:0];
    if (wr_mem1) ram1[mar1] <= bus_v1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // per-cycle monitor of one DUT: strobe rules, write scoreboard, done capture
  task automatic mon(input int d, input logic rdy, input logic [7:0] bo, input logic bd,
                     input logic wa, input logic wm, input logic ch, input logic dn,
                     input logic er, input logic [3:0] la, input logic [3:0] mar);
    logic [11:0] e;
    check("bus_drive", bd, wa | wm);
    if (!bd) check("bus_idle_zero", bo, 0);
    check("strobe_onehot", wa & wm, 0);
    check("strobe_in_wait", rdy & (wa | wm), 0);
    if (ch) hold_cnt[d]++;
    if (d == 1 && reset) vph = 0;
    if (wm) begin
      wr_cnt[d]++;
      if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
        check("wr_unexpected", 1, 0);
      end else begin
        if (d == 0) e = exp_q0.pop_front();
        else e = exp_q1.pop_front();
        check("wr_addr", mar, e[11:8]);
        check("wr_data", bo, e[7:0]);
        if (d == 1 && e[11:8] == 4'hF) begin
          vph = 1;
          v_idx = 0;
        end
      end
    end
    if (d == 1 && vph && wa) begin
      check("v_adr_bus", bo, v_idx);
      check("v_adr_load_addr", la, v_idx);
      v_idx++;
    end
    if (dn) begin
      done_seen[d] = 1;
      done_cyc[d]  = cyc;
      done_err[d]  = er;
      done_addr[d] = la;
      check("done_hold_low", ch, 0);
      if (d == 1) begin
        check("v_count", v_idx, 16);
        vph = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, in_ready0, bus_out0, bus_drive0, wr_mem_adr0, wr_mem0, cpu_hold0,
        done0, error0, load_addr0, mar0);
    mon(1, in_ready1, bus_out1, bus_drive1, wr_mem_adr1, wr_mem1, cpu_hold1,
        done1, error1, load_addr1, mar1);
  end

  // driver: pulse start, check the restart state
  task automatic begin_load();
    for (int i = 0; i < 2; i++) begin
      done_seen[i] = 0;
      hold_cnt[i] = 0;
      wr_cnt[i] = 0;
    end
    b_idx = 0;
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    check("start_load_addr0", load_addr0, 0);
    check("start_load_addr1", load_addr1, 0);
    check("start_error0", error0, 0);
    check("start_error1", error1, 0);
    check("start_ready0", in_ready0, 1);
    check("start_hold1", cpu_hold1, 1);
  endtask

  // driver: present one byte after gap idle cycles, hold until accepted
  task automatic send_byte(input logic [7:0] d, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    t = 0;
    while (!in_ready0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", in_ready0, 1);
    check("ready_match", in_ready1, in_ready0);
    exp_q0.push_back({b_idx[3:0], d});
    exp_q1.push_back({b_idx[3:0], d});
    sent[b_idx] = d;
    b_idx++;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!(done_seen[0] && done_seen[1]) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("done_timeout", {31'd0, done_seen[0] & done_seen[1]}, 1);
    @(negedge clk);
    check("idle_busy0", busy0, 0);
    check("idle_busy1", busy1, 0);
    check("queue_empty0", exp_q0.size(), 0);
    check("queue_empty1", exp_q1.size(), 0);
    check("wr_count0", wr_cnt[0], 16);
    check("wr_count1", wr_cnt[1], 16);
    check("done_addr0", done_addr[0], 15);
    check("done_addr1", done_addr[1], 15);
    check("done_error0", done_err[0], 0);
  endtask

  task automatic check_ram();
    for (int i = 0; i < 16; i++) begin
      check("ram0", ram0[i], sent[i]);
      check("ram1", ram1[i], sent[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    vph = 0;
    v_idx = 0;
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    corrupt = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs0", outs0, 0);
    check("reset_outs1", outs1, 0);
    reset = 1'b0;
    @(negedge clk);

    // basic load 0x00..0x0F back to back (readback honest on dut1)
    begin_load();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
    wait_done();
    check("latency_noverify", done_cyc[0] - s_cyc + 1, 50);
    check("latency_verify", done_cyc[1] - s_cyc + 1, 83);
    // hold covers WAIT/SET_ADR/WRITE (3 per byte), plus readback and CHECK
    check("hold_cycles0", hold_cnt[0], 48);
    check("hold_cycles1", hold_cnt[1], 81);
    check("verify_ok_error", done_err[1], 0);
    check_ram();

    // readback with address 5 corrupted: 0x78 sent vs 0x72 read
    corrupt = 1'b1;
    begin_load();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
    wait_done();
    check("verify_bad_error", done_err[1], 1);
    repeat (5) @(negedge clk);
    check("error_sticky", error1, 1);
    corrupt = 1'b0;

    // back-pressure, 0xAB at index 3
    begin_load();
    for (int i = 0; i < 16; i++) begin
      send_byte((i == 3) ? 8'hAB : 8'($urandom_range(0, 255)), i % 3);
    end
    wait_done();
    check("bp_verify_error", done_err[1], 0);
    check("bp_ram3", ram0[3], 8'hAB);
    check_ram();

    // reset during the write of index 7
    begin_load();
    for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i), 0);
    @(negedge clk);
    check("t5_in_write", wr_mem0, 1);
    check("t5_write_addr", load_addr0, 7);
    reset = 1'b1;
    @(negedge clk);
    check("t5_reset_outs0", outs0, 0);
    check("t5_reset_outs1", outs1, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    for (int i = 0; i < 7; i++) begin
      check("t5_ram0_kept", ram0[i], 8'h40 + 8'(i));
      check("t5_ram1_kept", ram1[i], 8'h40 + 8'(i));
    end
    @(negedge clk);

    // start pulse while waiting for index 2 is ignored; wrap at the end
    begin_load();
    send_byte(8'h10, 0);
    send_byte(8'h11, 0);
    while (!in_ready0) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_addr_kept", load_addr0, 2);
    check("t6_busy", busy0, 1);
    for (int i = 2; i < 16; i++) send_byte(8'h10 + 8'(i), 0);
    wait_done();
    check("t6_latency0", done_cyc[0] - s_cyc + 1, 51);
    check("t6_latency1", done_cyc[1] - s_cyc + 1, 84);
    check("t6_verify_error", done_err[1], 0);
    check_ram();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
